// File: rtl/lpm_pkg.sv
// Shared definitions for the Lpm say/heard protocol: payload and error
// counter widths, the client state encoding and a saturating counter helper.
package lpm_pkg;

   localparam int LPM_WIDTH = 32;
   localparam int ERR_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } lpm_client_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
      logic [ERR_W-1:0] res;
      if (cnt == {ERR_W{1'b1}}) begin
         res = cnt;
      end else begin
         res = cnt + ERR_W'(1);
      end
      return res;
   endfunction

endpackage

// File: rtl/lpm_client_if.sv
// Bundle of the start, say, heard and status signals of an Lpm client.
// The master side is the client itself; the slave side is whatever drives
// start, serves say and delivers heard (an Lpm instance or a bench).
interface lpm_client_if
   import lpm_pkg::*;
#(
   parameter int WIDTH = LPM_WIDTH
) ();

   logic              start__ENA;
   logic [31:0]       start_count;
   logic [WIDTH-1:0]  start_meth;
   logic [WIDTH-1:0]  start_v;
   logic              start__RDY;

   logic              say__ENA;
   logic [WIDTH-1:0]  say_meth;
   logic [WIDTH-1:0]  say_v;
   logic              say__RDY;

   logic              heard__ENA;
   logic [WIDTH-1:0]  heard_meth;
   logic [WIDTH-1:0]  heard_v;
   logic              heard__RDY;

   logic              done;
   logic [ERR_W-1:0]  err_count;

   modport master (
      input  start__ENA, start_count, start_meth, start_v,
      output start__RDY,
      output say__ENA, say_meth, say_v,
      input  say__RDY,
      input  heard__ENA, heard_meth, heard_v,
      output heard__RDY,
      output done, err_count
   );

   modport slave (
      output start__ENA, start_count, start_meth, start_v,
      input  start__RDY,
      input  say__ENA, say_meth, say_v,
      output say__RDY,
      output heard__ENA, heard_meth, heard_v,
      input  heard__RDY,
      input  done, err_count
   );

endinterface

// File: rtl/lpm_client.sv
// Lpm initiator: issues a burst of say(meth, base_v + i) requests under an
// outstanding-request window and checks the in-order heard indications
// against the same sequence. Because Lpm answers in order, tracking is just
// three counters (issued, received, outstanding).
module lpm_client
   import lpm_pkg::*;
#(
   parameter int WIDTH           = LPM_WIDTH,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic         CLK,
   input  logic         nRST,   // active-high synchronous reset
   lpm_client_if.master bus
);

   localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUTSTANDING);

   lpm_client_state_t state_q;
   logic [WIDTH-1:0]  meth_q;
   logic [WIDTH-1:0]  base_v_q;
   logic [31:0]       count_q;
   logic [31:0]       issued_q;
   logic [31:0]       received_q;
   logic [7:0]        outstanding_q;
   logic [ERR_W-1:0]  err_q;
   logic              done_q;

   logic              say_ena_s;
   logic [WIDTH-1:0]  say_v_s;
   logic              heard_rdy_s;
   logic              heard_acc_s;
   logic [WIDTH-1:0]  exp_v_s;
   logic              mismatch_s;
   logic              start_rdy_s;

   // Handshake decode: issue/accept qualifiers and payload arithmetic from registers.
   always_comb begin
      start_rdy_s = (state_q == ST_IDLE) || (state_q == ST_DONE);
      say_ena_s   = (state_q == ST_RUN) && (issued_q < count_q) &&
                    (outstanding_q < MAX_OUT_C) && bus.say__RDY;
      say_v_s     = base_v_q + WIDTH'(issued_q);
      heard_rdy_s = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                    (outstanding_q != 8'd0);
      heard_acc_s = bus.heard__ENA && heard_rdy_s;
      exp_v_s     = base_v_q + WIDTH'(received_q);
      mismatch_s  = (bus.heard_meth != meth_q) || (bus.heard_v != exp_v_s);
   end

   assign bus.start__RDY = start_rdy_s;
   assign bus.say__ENA   = say_ena_s;
   assign bus.say_meth   = meth_q;
   assign bus.say_v      = say_v_s;
   assign bus.heard__RDY = heard_rdy_s;
   assign bus.done       = done_q;
   assign bus.err_count  = err_q;

   // Burst FSM with its counters, error tally and registered done flag.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         state_q       <= ST_IDLE;
         meth_q        <= '0;
         base_v_q      <= '0;
         count_q       <= 32'd0;
         issued_q      <= 32'd0;
         received_q    <= 32'd0;
         outstanding_q <= 8'd0;
         err_q         <= '0;
         done_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start__ENA) begin
                  meth_q        <= bus.start_meth;
                  base_v_q      <= bus.start_v;
                  count_q       <= bus.start_count;
                  issued_q      <= 32'd0;
                  received_q    <= 32'd0;
                  outstanding_q <= 8'd0;
                  err_q         <= '0;
                  if (bus.start_count == 32'd0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                     done_q  <= 1'b0;
                  end
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (say_ena_s) begin
                  issued_q <= issued_q + 32'd1;
               end
               if (heard_acc_s) begin
                  received_q <= received_q + 32'd1;
                  if (mismatch_s) begin
                     err_q <= sat_inc(err_q);
                  end
               end
               case ({say_ena_s, heard_acc_s})
                  2'b10:   outstanding_q <= outstanding_q + 8'd1;
                  2'b01:   outstanding_q <= outstanding_q - 8'd1;
                  default: outstanding_q <= outstanding_q;
               endcase
               // A final heard can only come after the last say, so RUN
               // always goes through DRAIN on its way to DONE.
               if ((state_q == ST_RUN) && say_ena_s &&
                   ((issued_q + 32'd1) == count_q)) begin
                  state_q <= ST_DRAIN;
               end else if ((state_q == ST_DRAIN) && heard_acc_s &&
                            ((received_q + 32'd1) == count_q)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lpm_client.sv
// Directed bench for lpm_client with a one-cycle-latency in-order Lpm model
// that echoes every say back as a heard, with optional stall and corruption.
module tb_lpm_client;

   logic CLK;
   logic nRST;

   lpm_client_if #(.WIDTH(32)) bus ();

   lpm_client #(.WIDTH(32), .MAX_OUTSTANDING(4)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks;
   int n_errors;
   int cyc;
   int start_cyc;
   int first_say_cyc;
   int last_say_cyc;
   int last_heard_cyc;
   int heard_idx;
   int corrupt_idx;
   logic stall;

   logic [31:0] q_v[$];
   logic [31:0] q_m[$];
   logic [31:0] say_log[$];
   logic [31:0] say_meth_log[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive heard from the model, log the transfers that
   // happen on the coming edge, then sample just after that edge.
   task automatic step();
      @(negedge CLK);
      if (!stall && (q_v.size() > 0)) begin
         bus.heard__ENA = 1'b1;
         bus.heard_meth = q_m[0];
         bus.heard_v    = (heard_idx == corrupt_idx) ? (q_v[0] + 32'd1) : q_v[0];
      end else begin
         bus.heard__ENA = 1'b0;
         bus.heard_meth = 32'd0;
         bus.heard_v    = 32'd0;
      end
      #1;
      if (bus.heard__ENA && bus.heard__RDY) begin
         void'(q_v.pop_front());
         void'(q_m.pop_front());
         heard_idx++;
         last_heard_cyc = cyc + 1;
      end
      if (bus.say__ENA) begin
         q_v.push_back(bus.say_v);
         q_m.push_back(bus.say_meth);
         say_log.push_back(bus.say_v);
         say_meth_log.push_back(bus.say_meth);
         if (first_say_cyc < 0) first_say_cyc = cyc + 1;
         last_say_cyc = cyc + 1;
      end
      @(posedge CLK);
      cyc++;
      #1;
   endtask

   task automatic reset_model();
      q_v.delete();
      q_m.delete();
      say_log.delete();
      say_meth_log.delete();
      heard_idx      = 0;
      corrupt_idx    = -1;
      first_say_cyc  = -1;
      last_say_cyc   = -1;
      last_heard_cyc = -1;
      stall          = 1'b0;
   endtask

   task automatic start_burst(input logic [31:0] count, input logic [31:0] meth, input logic [31:0] v);
      reset_model();
      bus.start_count = count;
      bus.start_meth  = meth;
      bus.start_v     = v;
      bus.start__ENA  = 1'b1;
      step();
      start_cyc      = cyc;
      bus.start__ENA = 1'b0;
   endtask

   task automatic run_to_done(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (bus.done) break;
         step();
      end
      check_eq(tag, 64'(bus.done), 64'd1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      CLK      = 1'b0;
      nRST     = 1'b1;
      bus.start__ENA  = 1'b0;
      bus.start_count = 32'd0;
      bus.start_meth  = 32'd0;
      bus.start_v     = 32'd0;
      bus.say__RDY    = 1'b1;
      bus.heard__ENA  = 1'b0;
      bus.heard_meth  = 32'd0;
      bus.heard_v     = 32'd0;
      reset_model();

      // Reset state
      step();
      step();
      check_eq("rst_start_rdy", 64'(bus.start__RDY), 64'd1);
      check_eq("rst_say_ena",   64'(bus.say__ENA),   64'd0);
      check_eq("rst_heard_rdy", 64'(bus.heard__RDY), 64'd0);
      check_eq("rst_done",      64'(bus.done),       64'd0);
      check_eq("rst_err",       64'(bus.err_count),  64'd0);
      nRST = 1'b0;
      step();

      // Loopback burst: count=8, meth=3, v=100
      start_burst(32'd8, 32'd3, 32'd100);
      check_eq("lb_start_rdy_busy", 64'(bus.start__RDY), 64'd0);
      run_to_done("lb_done", 40);
      check_eq("lb_says", 64'(say_log.size()), 64'd8);
      for (int i = 0; i < say_log.size(); i++) begin
         check_eq("lb_say_v", 64'(say_log[i]), 64'(100 + i));
      end
      check_eq("lb_say_meth", 64'(say_meth_log[0]), 64'd3);
      check_eq("lb_heards", 64'(heard_idx), 64'd8);
      check_eq("lb_err", 64'(bus.err_count), 64'd0);
      check_eq("lb_first_say_lat", 64'(first_say_cyc - start_cyc), 64'd1);
      check_eq("lb_throughput", 64'(last_say_cyc - start_cyc), 64'd8);
      check_eq("lb_done_after_heard", 64'(cyc - last_heard_cyc), 64'd0);
      check_eq("lb_start_rdy_done", 64'(bus.start__RDY), 64'd1);

      // Window limit: responses stalled, count=10
      start_burst(32'd10, 32'd4, 32'd0);
      stall = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check_eq("win_says", 64'(say_log.size()), 64'd4);
      check_eq("win_say_ena_low", 64'(bus.say__ENA), 64'd0);
      check_eq("win_heard_rdy", 64'(bus.heard__RDY), 64'd1);
      check_eq("win_not_done", 64'(bus.done), 64'd0);
      stall = 1'b0;
      run_to_done("win_done", 60);
      check_eq("win_says_all", 64'(say_log.size()), 64'd10);
      check_eq("win_err", 64'(bus.err_count), 64'd0);

      // Corruption on the 3rd response of count=5
      start_burst(32'd5, 32'd7, 32'd20);
      corrupt_idx = 2;
      run_to_done("cor_done", 40);
      check_eq("cor_err", 64'(bus.err_count), 64'd1);
      check_eq("cor_heards", 64'(heard_idx), 64'd5);

      // count=0 goes straight to DONE
      start_burst(32'd0, 32'd1, 32'd1);
      check_eq("zero_done", 64'(bus.done), 64'd1);
      check_eq("zero_start_rdy", 64'(bus.start__RDY), 64'd1);
      check_eq("zero_err_cleared", 64'(bus.err_count), 64'd0);
      step();
      check_eq("zero_no_say", 64'(say_log.size()), 64'd0);

      // Payload wrap-around
      start_burst(32'd3, 32'd5, 32'hFFFF_FFFE);
      run_to_done("wrap_done", 30);
      check_eq("wrap_says", 64'(say_log.size()), 64'd3);
      if (say_log.size() == 3) begin
         check_eq("wrap_v0", 64'(say_log[0]), 64'h0000_0000_FFFF_FFFE);
         check_eq("wrap_v1", 64'(say_log[1]), 64'h0000_0000_FFFF_FFFF);
         check_eq("wrap_v2", 64'(say_log[2]), 64'h0000_0000_0000_0000);
      end
      check_eq("wrap_err", 64'(bus.err_count), 64'd0);

      // Reset mid-burst after 2 says
      start_burst(32'd8, 32'd2, 32'd10);
      stall = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (say_log.size() >= 2) break;
         step();
      end
      check_eq("mid_says_before_rst", 64'(say_log.size()), 64'd2);
      bus.say__RDY = 1'b0;
      nRST = 1'b1;
      step();
      nRST = 1'b0;
      bus.say__RDY = 1'b1;
      check_eq("mid_say_ena", 64'(bus.say__ENA), 64'd0);
      check_eq("mid_heard_rdy", 64'(bus.heard__RDY), 64'd0);
      check_eq("mid_start_rdy", 64'(bus.start__RDY), 64'd1);
      check_eq("mid_done", 64'(bus.done), 64'd0);
      check_eq("mid_err", 64'(bus.err_count), 64'd0);
      stall = 1'b0;
      step();
      step();
      check_eq("mid_late_heard_refused", 64'(heard_idx), 64'd0);
      start_burst(32'd4, 32'd6, 32'd7);
      run_to_done("mid_restart_done", 30);
      check_eq("mid_restart_says", 64'(say_log.size()), 64'd4);
      check_eq("mid_restart_v0", 64'(say_log[0]), 64'd7);
      check_eq("mid_restart_err", 64'(bus.err_count), 64'd0);

      // Start pulse while busy is ignored
      start_burst(32'd6, 32'd9, 32'd50);
      step();
      step();
      check_eq("busy_start_rdy", 64'(bus.start__RDY), 64'd0);
      bus.start_count = 32'd2;
      bus.start_meth  = 32'd1;
      bus.start_v     = 32'd0;
      bus.start__ENA  = 1'b1;
      step();
      bus.start__ENA  = 1'b0;
      run_to_done("busy_done", 40);
      check_eq("busy_says", 64'(say_log.size()), 64'd6);
      check_eq("busy_last_v", 64'(say_log[say_log.size()-1]), 64'd55);
      check_eq("busy_meth", 64'(say_meth_log[say_meth_log.size()-1]), 64'd9);
      check_eq("busy_err", 64'(bus.err_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
